// File: rtl/mult_cla_pkg.sv
// Shared definitions for the sequential shift-add multiplier: default width and FSM encoding.
package mult_cla_pkg;
  localparam int N_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/cla_adder.sv
// N-bit combinational adder: 4-bit carry-lookahead groups, carry rippled between groups.
module cla_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  localparam int GROUPS = N / 4;

  logic [N:0] c;
  assign c[0] = cin;

  for (genvar gi = 0; gi < GROUPS; gi++) begin : g_grp
    logic [3:0] gg, pp;
    logic       ci;
    assign gg = a[4*gi +: 4] & b[4*gi +: 4];
    assign pp = a[4*gi +: 4] ^ b[4*gi +: 4];
    assign ci = c[4*gi];

    // All four carries derive from the group carry-in only, not from each other.
    assign c[4*gi+1] = gg[0] | (pp[0] & ci);
    assign c[4*gi+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
    assign c[4*gi+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                     | (pp[2] & pp[1] & pp[0] & ci);
    assign c[4*gi+4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                     | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & ci);

    assign sum[4*gi +: 4] = pp ^ c[4*gi +: 4];
  end

  assign cout = c[N];
endmodule

// File: rtl/mult_cla.sv
// Sequential unsigned N x N radix-2 shift-add multiplier; one CLA step per clock, start/valid handshake.
module mult_cla
  import mult_cla_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   multiplier,
  input  logic [N-1:0]   multiplicand,
  output logic [2*N-1:0] product,
  output logic           valid
);
  localparam int CW = $clog2(N) + 1;

  state_e        state_q;
  logic [N-1:0]  m_q, a_q, q_q;
  logic [CW-1:0] cnt_q;

  logic [N-1:0]  add_sum, sum_d, a_d, q_d;
  logic          add_cout, c_d;

  cla_adder #(.N(N)) u_add (
    .a    (a_q),
    .b    (m_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // The step carry lands in A's MSB after the shift, so the C position is
  // always zero afterwards and needs no storage of its own.
  always_comb begin
    sum_d = q_q[0] ? add_sum : a_q;
    c_d   = q_q[0] & add_cout;
    a_d   = {c_d, sum_d[N-1:1]};
    q_d   = {sum_d[0], q_q[N-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      product <= '0;
      valid   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            m_q     <= multiplicand;
            q_q     <= multiplier;
            a_q     <= '0;
            cnt_q   <= '0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          a_q   <= a_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) state_q <= ST_DONE;
        end
        ST_DONE: begin
          product <= {a_q, q_q};
          valid   <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_cla.sv
// Self-checking bench for mult_cla: vector table, reset/busy corner sequences, back-to-back random run.
module tb_mult_cla;
  localparam int N = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [N-1:0]   multiplier = '0;
  logic [N-1:0]   multiplicand = '0;
  logic [2*N-1:0] product;
  logic           valid;

  mult_cla #(.N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .product      (product),
    .valid        (valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int          npass = 0, ntot = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_head;
  int          valid_cnt = 0, last_valid_cyc = 0;
  bit          chk_spacing = 1'b0, spacing_armed = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  // Output monitor: every valid pulse pops the scoreboard.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_cnt++;
      if (sb.size() == 0) chk("spurious_valid", {63'b0, valid}, 64'd0);
      else begin
        exp_head = sb.pop_front();
        chk("product", product, exp_head);
      end
      if (chk_spacing && spacing_armed) chk("spacing", 64'(cyc - last_valid_cyc), 64'(N + 2));
      spacing_armed  = chk_spacing;
      last_valid_cyc = cyc;
    end
  end

  task automatic wait_valid(input int c0);
    for (int t = 0; t < N + 10 && valid_cnt == c0; t++) begin
      @(negedge clk); #1;
    end
    if (valid_cnt == c0) chk("valid_timeout", 64'(valid_cnt), 64'(c0 + 1));
  endtask

  task automatic run_op(input logic [31:0] mr, input logic [31:0] md,
                        input logic [63:0] exp, input int extra, input string nm);
    int c0, k;
    multiplier = mr; multiplicand = md; start = 1'b1;
    @(posedge clk); #1;
    k  = cyc;
    c0 = valid_cnt;
    sb.push_back(exp);
    if (extra > 0) begin
      multiplier = 32'h3; multiplicand = 32'h5;
      repeat (extra) @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_valid(c0);
    chk({nm, "_latency"}, 64'(last_valid_cyc - k), 64'(N + 1));
    repeat (N + 4) @(posedge clk);
    #1;
    chk({nm, "_pulses"}, 64'(valid_cnt - c0), 64'd1);
    chk({nm, "_hold"}, product, exp);
  endtask

  typedef struct {
    logic [31:0] mr;
    logic [31:0] md;
    logic [63:0] exp;
    int          extra;
    string       nm;
  } vec_t;

  vec_t vt[8];

  initial begin
    int c0, k;
    logic [31:0] ra, rb;

    vt[0] = '{32'hFFFF_FFFF, 32'h0000_0100, 64'h0000_00FF_FFFF_FF00, 1, "ff_x_100"};
    vt[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, "max_x_max"};
    vt[2] = '{32'h0000_0000, 32'h1234_5678, 64'h0,                   0, "zero_x_val"};
    vt[3] = '{32'h1234_5678, 32'h0000_0000, 64'h0,                   0, "val_x_zero"};
    vt[4] = '{32'h0000_0007, 32'h0000_0009, 64'd63,                  0, "7_x_9"};
    vt[5] = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 0, "msb_x_2"};
    vt[6] = '{32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF, 0, "max_x_1"};
    vt[7] = '{32'hDEAD_BEEF, 32'h0000_0010, 64'h0000_000D_EADB_EEF0, 0, "deadbeef_x_10"};

    // Reset held 5 cycles, released with start low.
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("reset_product", product, 64'd0);
    chk("reset_valid", {63'b0, valid}, 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("reset_no_pulse", 64'(valid_cnt), 64'd0);

    foreach (vt[i]) run_op(vt[i].mr, vt[i].md, vt[i].exp, vt[i].extra, vt[i].nm);

    // Reset in the middle of an operation aborts it silently.
    multiplier = 32'd7; multiplicand = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c0 = valid_cnt;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (N + 5) @(posedge clk);
    #1;
    chk("abort_no_pulse", 64'(valid_cnt - c0), 64'd0);
    chk("abort_product", product, 64'd0);
    run_op(32'd7, 32'd9, 64'd63, 0, "after_abort");

    // start with other operands while BUSY is ignored.
    multiplier = 32'h0000_1234; multiplicand = 32'h0000_5678; start = 1'b1;
    @(posedge clk); #1;
    k = cyc; c0 = valid_cnt;
    sb.push_back(64'h0000_0000_0626_0060);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    multiplier = 32'hAAAA_AAAA; multiplicand = 32'h5555_5555; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    wait_valid(c0);
    chk("busy_latency", 64'(last_valid_cyc - k), 64'(N + 1));
    repeat (N + 4) @(posedge clk);
    #1;
    chk("busy_pulses", 64'(valid_cnt - c0), 64'd1);

    // Back-to-back random operations with start held high.
    chk_spacing = 1'b1;
    c0 = valid_cnt;
    ra = $urandom; rb = $urandom;
    multiplier = ra; multiplicand = rb; start = 1'b1;
    sb.push_back(ref_mul(ra, rb));
    @(posedge clk); #1;
    for (int i = 1; i < 1000; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 50 == 0) ra = 32'hFFFF_FFFF;
      if (i % 77 == 0) rb = 32'h0;
      multiplier = ra; multiplicand = rb;
      sb.push_back(ref_mul(ra, rb));
      wait_valid(valid_cnt);
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_valid(valid_cnt);
    chk_spacing = 1'b0;
    chk("rand_count", 64'(valid_cnt - c0), 64'd1000);
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
